// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch front end: default widths, instruction field
// positions and the fetch FSM state encoding.
package cpu_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_RESET_PC = 0;

   localparam int OP1_HI   = 15;
   localparam int COND_HI  = 11;
   localparam int OP2_HI   = 7;
   localparam int SHAMT_HI = 3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Program-memory read port: a request/address pair answered by ack/data.
interface pc_fetch_unit_if #(
   parameter int WIDTH = cpu_pkg::DEF_WIDTH
) ();

   logic             memReq;
   logic [WIDTH-1:0] memAddr;
   logic             memAck;
   logic [WIDTH-1:0] memData;

   modport master (
      output memReq,
      output memAddr,
      input  memAck,
      input  memData
   );

   modport slave (
      input  memReq,
      input  memAddr,
      output memAck,
      output memData
   );

endinterface

// File: rtl/pc_fetch_unit_pc_next_logic.sv
// Next-PC selection: jump-and-link, register jump, relative branch or increment,
// in that priority order. Pure combinational.
module pc_next_logic #(
   parameter int WIDTH = cpu_pkg::DEF_WIDTH
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] jumpTarget,
   input  logic [7:0]       imm8,
   input  logic             BranchEN,
   input  logic             JmpEN,
   input  logic             JALEN,
   output logic [WIDTH-1:0] pc_next,
   output logic             link_we
);

   logic [WIDTH-1:0] disp;

   assign disp = {{(WIDTH-8){imm8[7]}}, imm8};

   // NOTE: every output gets a default first so no path through the if-chain can infer a latch.
   always_comb begin
      link_we = JALEN;
      pc_next = pc + WIDTH'(1);
      if (JALEN || JmpEN) begin
         pc_next = jumpTarget;
      end else if (BranchEN) begin
         pc_next = pc + disp;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and link register with the two-state
// instruction-fetch handshake; exposes the decoded instruction fields.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               nextInstruction,
   input  logic               PCEN,
   input  logic               PCinstruction,
   input  logic               BranchEN,
   input  logic               JmpEN,
   input  logic               JALEN,
   input  logic [WIDTH-1:0]   jumpTarget,
   pc_fetch_unit_if.master    mem,
   output logic               busy,
   output logic               instrValid,
   output logic [WIDTH-1:0]   pc,
   output logic [WIDTH-1:0]   link,
   output logic [3:0]         opCode1,
   output logic [3:0]         conditionCode,
   output logic [3:0]         opCode2,
   output logic [3:0]         shiftAmt,
   output logic [7:0]         imm8
);

   fetch_state_t     state, state_next;
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] pc_next;
   logic             link_we;

   // NOTE: sequential state uses non-blocking assignments and an asynchronous reset branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (nextInstruction) state_next = S_WAIT;
         S_WAIT:  if (mem.memAck)      state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Request is decoded straight from the state flop, so reset drops it at once.
   always_comb begin
      mem.memReq = 1'b0;
      busy       = 1'b0;
      if (state == S_WAIT) begin
         mem.memReq = 1'b1;
         busy       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem.memAddr <= '0;
         ir          <= '0;
         instrValid  <= 1'b0;
      end else begin
         if (state == S_IDLE && nextInstruction) begin
            mem.memAddr <= pc;
            instrValid  <= 1'b0;
         end
         if (state == S_WAIT && mem.memAck) begin
            ir         <= mem.memData;
            instrValid <= 1'b1;
         end
      end
   end

   pc_next_logic #(.WIDTH(WIDTH)) u_pc_next (
      .pc         (pc),
      .jumpTarget (jumpTarget),
      .imm8       (imm8),
      .BranchEN   (BranchEN),
      .JmpEN      (JmpEN),
      .JALEN      (JALEN),
      .pc_next    (pc_next),
      .link_we    (link_we)
   );

   // Link captures the pre-jump pc, i.e. the address of the JAL itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc   <= RESET_PC;
         link <= '0;
      end else if (PCEN && PCinstruction) begin
         pc <= pc_next;
         if (link_we) link <= pc;
      end
   end

   assign opCode1       = ir[OP1_HI   -: 4];
   assign conditionCode = ir[COND_HI  -: 4];
   assign opCode2       = ir[OP2_HI   -: 4];
   assign shiftAmt      = ir[SHAMT_HI -: 4];
   assign imm8          = ir[OP2_HI   -: 8];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus pushes expected fetches
// and PC updates into queues that independent monitors drain and compare.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        nextInstruction, PCEN, PCinstruction, BranchEN, JmpEN, JALEN;
   logic [15:0] jumpTarget;
   logic        busy, instrValid;
   logic [15:0] pc, link;
   logic [3:0]  opCode1, conditionCode, opCode2, shiftAmt;
   logic [7:0]  imm8;

   pc_fetch_unit_if #(.WIDTH(16)) mem_bus ();

   pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .nextInstruction (nextInstruction),
      .PCEN            (PCEN),
      .PCinstruction   (PCinstruction),
      .BranchEN        (BranchEN),
      .JmpEN           (JmpEN),
      .JALEN           (JALEN),
      .jumpTarget      (jumpTarget),
      .mem             (mem_bus.master),
      .busy            (busy),
      .instrValid      (instrValid),
      .pc              (pc),
      .link            (link),
      .opCode1         (opCode1),
      .conditionCode   (conditionCode),
      .opCode2         (opCode2),
      .shiftAmt        (shiftAmt),
      .imm8            (imm8)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int req_rises = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] link;
   } pc_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  op1;
      logic [3:0]  cond;
      logic [3:0]  op2;
      logic [3:0]  shamt;
   } fetch_exp_t;

   pc_exp_t    pc_q[$];
   fetch_exp_t fetch_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Fetch monitor: counts request rises and scores every completed fetch.
   logic prev_valid = 1'b0;
   logic prev_req   = 1'b0;
   always @(negedge clk) begin
      fetch_exp_t e;
      if (mem_bus.memReq === 1'b1 && prev_req !== 1'b1) req_rises++;
      if (instrValid === 1'b1 && prev_valid !== 1'b1) begin
         if (fetch_q.size() == 0) begin
            check("unexpected_fetch", 32'(opCode1), 32'hFFFF_FFFF);
         end else begin
            e = fetch_q.pop_front();
            check("memAddr", 32'(mem_bus.memAddr), 32'(e.addr));
            check("opCode1", 32'(opCode1), 32'(e.op1));
            check("conditionCode", 32'(conditionCode), 32'(e.cond));
            check("opCode2", 32'(opCode2), 32'(e.op2));
            check("shiftAmt", 32'(shiftAmt), 32'(e.shamt));
            check("imm8", 32'(imm8), 32'({e.op2, e.shamt}));
         end
      end
      prev_req   = mem_bus.memReq;
      prev_valid = instrValid;
   end

   // PC monitor: every edge with PCEN high has an expected pc/link queued.
   always begin
      logic    strobe;
      pc_exp_t p;
      @(posedge clk);
      strobe = (PCEN === 1'b1) && (reset === 1'b0);
      @(negedge clk);
      if (strobe) begin
         if (pc_q.size() == 0) begin
            check("unexpected_pc_strobe", 32'(pc), 32'hFFFF_FFFF);
         end else begin
            p = pc_q.pop_front();
            check("pc", 32'(pc), 32'(p.pc));
            check("link", 32'(link), 32'(p.link));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pc_op(input logic qual, input logic br, input logic jmp, input logic jal,
                        input logic [15:0] tgt, input logic [15:0] exp_pc, input logic [15:0] exp_link);
      PCEN = 1'b1; PCinstruction = qual; BranchEN = br; JmpEN = jmp; JALEN = jal;
      jumpTarget = tgt;
      pc_q.push_back('{exp_pc, exp_link});
      tick();
      PCEN = 1'b0; PCinstruction = 1'b0; BranchEN = 1'b0; JmpEN = 1'b0; JALEN = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_bus.memReq !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check("memReq_seen", 32'(mem_bus.memReq), 32'd1);
   endtask

   task automatic fetch(input logic [15:0] data, input int delay, input logic [15:0] exp_addr,
                        input logic [3:0] o1, input logic [3:0] cc, input logic [3:0] o2, input logic [3:0] sa);
      fetch_q.push_back('{exp_addr, o1, cc, o2, sa});
      nextInstruction = 1'b1;
      tick();
      nextInstruction = 1'b0;
      wait_req();
      repeat (delay) tick();
      mem_bus.memAck = 1'b1; mem_bus.memData = data;
      tick();
      mem_bus.memAck = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset = 1'b1;
      nextInstruction = 1'b0; PCEN = 1'b0; PCinstruction = 1'b0;
      BranchEN = 1'b0; JmpEN = 1'b0; JALEN = 1'b0; jumpTarget = '0;
      mem_bus.memAck = 1'b0; mem_bus.memData = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      check("rst_pc", 32'(pc), 32'h0);
      check("rst_link", 32'(link), 32'h0);
      check("rst_memReq", 32'(mem_bus.memReq), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_instrValid", 32'(instrValid), 32'h0);
      check("rst_memAddr", 32'(mem_bus.memAddr), 32'h0);
      check("rst_ir", 32'({opCode1, conditionCode, imm8}), 32'h0);

      // Stray ack while idle must be ignored.
      mem_bus.memAck = 1'b1; mem_bus.memData = 16'h1234;
      tick();
      mem_bus.memAck = 1'b0;
      tick();
      check("idle_ack_valid", 32'(instrValid), 32'h0);
      check("idle_ack_imm8", 32'(imm8), 32'h0);

      fetch(16'h5A12, 0, 16'h0000, 4'h5, 4'hA, 4'h1, 4'h2);
      check("pc_after_fetch", 32'(pc), 32'h0);

      // Increment with wrap, then unqualified PCEN holds.
      pc_op(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000);
      pc_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      pc_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

      // Branch displacements -2, +127 and -128.
      fetch(16'h12FE, 0, 16'h0000, 4'h1, 4'h2, 4'hF, 4'hE);
      pc_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0000);
      pc_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h000E, 16'h0000);
      fetch(16'h347F, 1, 16'h000E, 4'h3, 4'h4, 4'h7, 4'hF);
      pc_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0000);
      pc_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h008F, 16'h0000);
      fetch(16'h0080, 0, 16'h008F, 4'h0, 4'h0, 4'h8, 4'h0);
      pc_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000);
      pc_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFF85, 16'h0000);

      // JAL together with JmpEN (and BranchEN) takes JAL semantics.
      pc_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0021, 16'h0000);
      pc_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0300, 16'h0300, 16'h0021);

      // Second nextInstruction during WAIT is ignored; PC increments mid-fetch.
      base = req_rises;
      fetch_q.push_back('{16'h0300, 4'hC, 4'h3, 4'hA, 4'h9});
      nextInstruction = 1'b1;
      tick();
      check("wait_busy", 32'(busy), 32'h1);
      check("wait_memReq", 32'(mem_bus.memReq), 32'h1);
      pc_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0301, 16'h0021);
      tick();
      nextInstruction = 1'b0;
      tick();
      mem_bus.memAck = 1'b1; mem_bus.memData = 16'hC3A9;
      tick();
      mem_bus.memAck = 1'b0;
      tick();
      tick();
      check("single_request", 32'(req_rises - base), 32'd1);
      check("pc_advanced", 32'(pc), 32'h0301);

      // Fetch and PC update on the same edge: address is the old pc.
      fetch_q.push_back('{16'h0301, 4'h7, 4'h6, 4'h5, 4'h4});
      nextInstruction = 1'b1;
      pc_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0302, 16'h0021);
      nextInstruction = 1'b0;
      wait_req();
      mem_bus.memAck = 1'b1; mem_bus.memData = 16'h7654;
      tick();
      mem_bus.memAck = 1'b0;
      tick();

      // Asynchronous reset in WAIT, then a late ack.
      nextInstruction = 1'b1;
      tick();
      nextInstruction = 1'b0;
      check("pre_reset_memReq", 32'(mem_bus.memReq), 32'h1);
      #1 reset = 1'b1;
      #1;
      check("async_memReq", 32'(mem_bus.memReq), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_pc", 32'(pc), 32'h0);
      check("async_link", 32'(link), 32'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      mem_bus.memAck = 1'b1; mem_bus.memData = 16'hFFFF;
      tick();
      mem_bus.memAck = 1'b0;
      tick();
      check("late_ack_valid", 32'(instrValid), 32'h0);
      check("late_ack_ir", 32'({opCode1, conditionCode, imm8}), 32'h0);

      tick();
      tick();
      check("pc_q_drained", 32'(pc_q.size()), 32'd0);
      check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the multicycle control FSM. Holds the program counter, the instruction register and the JAL link register.
- Runs the instruction-fetch handshake with program memory and slices the captured instruction into the fields the control FSM decodes.
- Applies the FSM's PC-update strobes: increment, relative branch, register jump, and jump-and-link.

Parameters:
- WIDTH, 16, datapath, instruction, PC and link width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- nextInstruction  in  1  FSM fetch strobe; starts a fetch of memory word at pc.
- PCEN  in  1  FSM PC write enable.
- PCinstruction  in  1  qualifies PCEN; a PC update occurs only when PCEN and PCinstruction are both 1.
- BranchEN  in  1  relative branch select.
- JmpEN  in  1  register-jump select.
- JALEN  in  1  jump-and-link select; also writes link.
- jumpTarget  in  WIDTH  Rtarget register value for JmpEN/JALEN.
- memAck  in  1  memory read data valid.
- memData  in  WIDTH  memory read data.
- memReq  out  1  fetch request, held until memAck.
- memAddr  out  WIDTH  fetch address, latched at request.
- busy  out  1  fetch in flight (state WAIT).
- instrValid  out  1  instruction register holds a completed fetch.
- pc  out  WIDTH  current program counter.
- link  out  WIDTH  JAL return address.
- opCode1  out  4  ir[15:12].
- conditionCode  out  4  ir[11:8]; also Rdest field.
- opCode2  out  4  ir[7:4].
- shiftAmt  out  4  ir[3:0].
- imm8  out  8  ir[7:0].

Behaviour:
- Reset (asynchronous, takes effect immediately, released synchronously):
  - pc=RESET_PC; ir=0; link=0; memAddr=0.
  - memReq=0; busy=0; instrValid=0; fetch FSM=IDLE.
  - A memAck arriving after reset is ignored.
- Fetch FSM states: IDLE, WAIT.
  - IDLE: if nextInstruction=1, memAddr<=pc, memReq<=1, instrValid<=0, go to WAIT.
  - WAIT: memReq=1, busy=1. On memAck=1: ir<=memData, instrValid<=1, memReq<=0, go to IDLE.
  - memAck is ignored in IDLE.
  - memAck on the same cycle memReq rises is not possible: memReq is registered, so the earliest ack is one cycle after entry to WAIT.
  - Minimum fetch latency: nextInstruction at edge N, memReq visible after edge N, ir valid after edge N+2 with single-cycle memory.
  - nextInstruction while in WAIT is ignored; no queueing.
- Field outputs are combinational slices of ir and stay stable between fetches.
- PC update, only when PCEN && PCinstruction at a rising edge. Priority:
  1. JALEN: link<=pc, pc<=jumpTarget.
  2. JmpEN: pc<=jumpTarget.
  3. BranchEN: pc<=pc+sext(imm8), with imm8 sign-extended to WIDTH.
  4. Otherwise: pc<=pc+1.
- Arithmetic is modulo 2^WIDTH:
  - pc=16'hFFFF plus increment gives 0.
  - Branch displacement 8'h80 means -128; pc=16'h0005 branching by -128 gives 16'hFF85.
- PCEN without PCinstruction, or PCEN=0: pc and link hold; branch/jump selects are ignored.
- A PC update while in WAIT is legal. The outstanding fetch still uses the latched memAddr.
- A PC update and nextInstruction on the same edge: memAddr captures the old pc (registered read).
- JALEN and JmpEN together: JALEN semantics (link written).

Decomposition:
- Shared package cpu_pkg: WIDTH default; field bit positions (OP1_HI=15, COND_HI=11, OP2_HI=7, SHAMT_HI=3); fetch state encoding; RESET_PC.
- One natural sub-module: pc_next_logic, the combinational priority mux plus adder producing next pc and link write enable.
- Instruction register and fetch FSM remain in the top module.

Test Plan:
- Reset/fetch: reset released, nextInstruction pulse, memAck one cycle after memReq with memData=16'h5A12 -> memAddr=0, opCode1=5, conditionCode=A, opCode2=1, shiftAmt=2, instrValid=1; pc unchanged at 0.
- Increment and wrap: pc=16'hFFFF, PCEN=PCinstruction=1, no selects -> pc=0. PCEN=1 with PCinstruction=0 -> pc holds.
- Branch: ir imm8=8'hFE, pc=16'h0010, PCEN+PCinstruction+BranchEN -> pc=16'h000E. With imm8=8'h7F -> pc=16'h008F.
- JAL: pc=16'h0021, jumpTarget=16'h0300, JALEN+JmpEN+PCEN+PCinstruction -> pc=16'h0300, link=16'h0021.
- Busy/ignore: nextInstruction during WAIT, plus a PC increment while waiting, then memAck after 3 cycles -> only one request; memAddr = pc at request; pc already advanced by 1.
- Async reset mid-fetch: assert reset in WAIT between clock edges -> memReq and busy drop immediately; a late memAck after release leaves ir=0 and instrValid=0.
